matmul_job_sequencer: RTL and testbench
=======================================

Name: matmul_job_sequencer

Overview:
Sequences one 3x3 fused matrix-multiply job on the PCPI matrix coprocessor.
- Takes the operand stream (A, B, bias, optional threshold) on a valid/ready port and converts each word into one custom-0 write instruction.
- Issues the start instruction, waits for the coprocessor's completion, then issues the clear instruction.
- Sits between a DMA/host front end and the coprocessor PCPI port, so software need not hand-issue 28+ custom instructions.

Parameters:
CUSTOM_OPCODE, 7'b0001011, opcode field [6:0] of every issued instruction
TIMEOUT_CYCLES, 64, maximum WAIT cycles before error
THR_ADDR, 27, coprocessor address of the threshold register

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
job_start  in  1  one-cycle pulse: begin job (ignored unless IDLE)
job_load_thr  in  1  sampled with job_start: 1 = stream carries a 28th threshold word
job_abort  in  1  terminate the active job via the CLEAR instruction
job_busy  out  1  high from the cycle after accepted job_start until DONE
job_done  out  1  one-cycle pulse at job end
job_err  out  1  set with job_done if timeout or abort; held until next job_start
s_valid  in  1  operand word valid
s_ready  out  1  operand word accepted when s_valid & s_ready
s_data  in  16  signed operand word
pcpi_valid  out  1  instruction valid to coprocessor (one-cycle pulse per instruction)
pcpi_insn  out  32  instruction to coprocessor
pcpi_wait  in  1  coprocessor busy
pcpi_ready  in  1  coprocessor ready/complete

Behaviour:
Reset (async, resetn=0):
- State = IDLE; all outputs 0; counters 0.

Instruction format:
- [6:0] = CUSTOM_OPCODE; [11:7] = address; [14:12] = funct3; [30:15] = value; [31] = 0.
- WRITE: funct3 = 000, address = word index, value = s_data.
- START: funct3 = 111, address and value 0.
- CLEAR: funct3 = 101, address and value 0.

States:
- IDLE: on job_start, latch job_load_thr, clear word_cnt and job_err, go to LOAD.
- LOAD:
  - s_ready = 1.
  - Each accepted word at cycle t produces pcpi_valid = 1 with the WRITE instruction at t+1 (registered outputs). Throughput is 1 word/cycle; s_valid gaps produce pcpi_valid = 0.
  - Word indices 0-8 map to A, 9-17 to B, 18-26 to bias, all row-major. The threshold word, when enabled, uses address THR_ADDR.
  - After the last word (index 26, or 27 with threshold) is accepted, s_ready drops in the next cycle; go to START.
- START: emit the START instruction for one cycle, then go to SETTLE.
- SETTLE: one idle cycle, pcpi_valid = 0. This covers the coprocessor's registered ready deassertion. Then go to WAIT with timer = 0.
- WAIT:
  - If pcpi_ready = 1 and pcpi_wait = 0, go to CLEAR.
  - Otherwise increment the timer. When timer = TIMEOUT_CYCLES-1, set job_err and go to CLEAR.
- CLEAR: emit the CLEAR instruction for one cycle, then go to DONE.
- DONE: job_done = 1 for one cycle; job_busy = 0 from this cycle; go to IDLE.

Abort:
- job_abort in LOAD, START, SETTLE or WAIT: set job_err, go to CLEAR next cycle.
- Any instruction pulse already registered is still emitted.
- job_abort is ignored in IDLE, CLEAR and DONE.

Boundary conditions:
- job_start while not IDLE: ignored, no effect on counters.
- job_start and job_abort in the same IDLE cycle: start wins.
- s_valid in IDLE, START, SETTLE, WAIT, CLEAR or DONE: s_ready = 0, word not consumed.
- Reset mid-job returns to IDLE immediately with no CLEAR issued. The coprocessor is reset by the same resetn.

Widths:
- word_cnt is 5 bits. timer is clog2(TIMEOUT_CYCLES) bits and saturates.

Decomposition:
- Shared package matmul_pcpi_pkg holds:
  - CUSTOM_OPCODE, FUNCT3_WRITE = 3'b000, FUNCT3_CLEAR = 3'b101, FUNCT3_START = 3'b111.
  - Address bases A_BASE = 0, B_BASE = 9, BIAS_BASE = 18, THR_ADDR = 27, N_OPERANDS = 27.
  - The state enum.
  - An insn-builder function (addr, funct3, value) -> 32-bit instruction.
- One sub-module is natural: matmul_insn_issue, the registered pcpi_valid/pcpi_insn output stage, fed by the FSM.

Test Plan:
- Back-to-back stream:
  - Stimulus: job_start (load_thr = 0), 27 words 1..27 with s_valid held high.
  - Required: 27 consecutive pcpi_valid pulses, addresses 0..26 and value = word; then START (insn 0x0000700B), one idle cycle; CLEAR (0x0000500B) after pcpi_ready; job_done with job_err = 0.
- Threshold word: load_thr = 1, 28th word = -70 -> insn address 27 with [30:15] = 0xFFBA; total 28 WRITE instructions.
- Gapped stream: s_valid toggles 1,0,1,0 -> pcpi_valid pulses appear only one cycle after each accepted word; addresses remain contiguous.
- Timeout: pcpi_ready held 0 after START -> CLEAR issued after 64 WAIT cycles; job_done with job_err = 1.
- Abort: job_abort at word 5 -> no further WRITEs; CLEAR the next cycle (or after the pending pulse); job_done with job_err = 1; s_ready = 0.
- Async reset mid-WAIT: resetn low between clock edges -> all outputs 0 immediately; after release, IDLE and a new job runs normally.

Source files
------------

// File: rtl/matmul_pcpi_pkg.sv
// Shared constants, state encoding and instruction helpers for the PCPI matrix job sequencer.
// Instruction layout: [31]=0, [30:15]=value, [14:12]=funct3, [11:7]=address, [6:0]=opcode.
package matmul_pcpi_pkg;

    localparam logic [6:0] CUSTOM_OPCODE = 7'b0001011;

    localparam logic [2:0] FUNCT3_WRITE = 3'b000;
    localparam logic [2:0] FUNCT3_CLEAR = 3'b101;
    localparam logic [2:0] FUNCT3_START = 3'b111;

    localparam logic [4:0] A_BASE     = 5'd0;
    localparam logic [4:0] B_BASE     = 5'd9;
    localparam logic [4:0] BIAS_BASE  = 5'd18;
    localparam logic [4:0] THR_ADDR   = 5'd27;
    localparam logic [4:0] N_OPERANDS = 5'd27;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StSettle,
        StWait,
        StClear,
        StDone
    } matmul_state_e;

    function automatic logic [31:0] build_insn(input logic [6:0]  opcode,
                                               input logic [4:0]  addr,
                                               input logic [2:0]  funct3,
                                               input logic [15:0] value);
        return {1'b0, value, funct3, addr, opcode};
    endfunction

    // Stream index -> coprocessor register: A, B, bias (row-major), then the threshold word.
    function automatic logic [4:0] operand_addr(input logic [4:0] idx,
                                                input logic [4:0] thr_addr);
        if (idx < B_BASE) begin
            return A_BASE + idx;
        end else if (idx < BIAS_BASE) begin
            return B_BASE + (idx - B_BASE);
        end else if (idx < N_OPERANDS) begin
            return BIAS_BASE + (idx - BIAS_BASE);
        end
        return thr_addr;
    endfunction

endpackage

// File: rtl/matmul_job_sequencer_if.sv
// Operand stream and PCPI instruction port of the matmul job sequencer.
interface matmul_job_sequencer_if;

    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_wait;
    logic        pcpi_ready;

    // master: the sequencer (stream sink, instruction source); slave: host and coprocessor side
    modport master (
        input  s_valid, s_data, pcpi_wait, pcpi_ready,
        output s_ready, pcpi_valid, pcpi_insn
    );

    modport slave (
        output s_valid, s_data, pcpi_wait, pcpi_ready,
        input  s_ready, pcpi_valid, pcpi_insn
    );

endinterface

// File: rtl/matmul_insn_issue.sv
// Registered PCPI output stage: one pcpi_valid pulse per issue request, insn held between pulses.
module matmul_insn_issue (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_en,
    input  logic [31:0] issue_insn,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
        end else begin
            pcpi_valid <= issue_en;
            if (issue_en) begin
                pcpi_insn <= issue_insn;
            end
        end
    end

endmodule

// File: rtl/matmul_job_sequencer.sv
// Converts an operand stream into coprocessor WRITE instructions, then runs START / wait / CLEAR
// for one 3x3 fused matrix-multiply job.
module matmul_job_sequencer #(
    parameter logic [6:0]  CUSTOM_OPCODE  = matmul_pcpi_pkg::CUSTOM_OPCODE,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [4:0]  THR_ADDR       = matmul_pcpi_pkg::THR_ADDR
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          job_start,
    input  logic                          job_load_thr,
    input  logic                          job_abort,
    output logic                          job_busy,
    output logic                          job_done,
    output logic                          job_err,
    matmul_job_sequencer_if.master        bus
);

    import matmul_pcpi_pkg::*;

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    matmul_state_e     state_q, state_d;
    logic [4:0]        word_cnt_q, word_cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              load_thr_q, load_thr_d;
    logic              err_q, err_d;

    logic              s_ready;
    logic              issue_en;
    logic [31:0]       issue_insn;
    logic [4:0]        last_idx;

    assign last_idx = load_thr_q ? N_OPERANDS : N_OPERANDS - 5'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            timer_q    <= '0;
            load_thr_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
            load_thr_q <= load_thr_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        load_thr_d = load_thr_q;
        err_d      = err_q;
        s_ready    = 1'b0;
        issue_en   = 1'b0;
        issue_insn = '0;

        unique case (state_q)
            StIdle: begin
                if (job_start) begin
                    load_thr_d = job_load_thr;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                // Abort withholds s_ready so the word offered in that cycle is never written.
                if (job_abort) begin
                    err_d   = 1'b1;
                    state_d = StClear;
                end else begin
                    s_ready = 1'b1;
                    if (bus.s_valid) begin
                        issue_en   = 1'b1;
                        issue_insn = build_insn(CUSTOM_OPCODE,
                                                operand_addr(word_cnt_q, THR_ADDR),
                                                FUNCT3_WRITE, bus.s_data);
                        word_cnt_d = word_cnt_q + 5'd1;
                        if (word_cnt_q == last_idx) begin
                            state_d = StStart;
                        end
                    end
                end
            end
            StStart: begin
                if (job_abort) begin
                    err_d   = 1'b1;
                    state_d = StClear;
                end else begin
                    issue_en   = 1'b1;
                    issue_insn = build_insn(CUSTOM_OPCODE, 5'd0, FUNCT3_START, 16'd0);
                    state_d    = StSettle;
                end
            end
            StSettle: begin
                if (job_abort) begin
                    err_d   = 1'b1;
                    state_d = StClear;
                end else begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (job_abort) begin
                    err_d   = 1'b1;
                    state_d = StClear;
                end else if (bus.pcpi_ready && !bus.pcpi_wait) begin
                    state_d = StClear;
                end else if (timer_q == TimerLast) begin
                    err_d   = 1'b1;
                    state_d = StClear;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StClear: begin
                issue_en   = 1'b1;
                issue_insn = build_insn(CUSTOM_OPCODE, 5'd0, FUNCT3_CLEAR, 16'd0);
                state_d    = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.s_ready = s_ready;
    assign job_busy    = (state_q != StIdle) && (state_q != StDone);
    assign job_done    = (state_q == StDone);
    assign job_err     = err_q;

    matmul_insn_issue u_issue (
        .clk        (clk),
        .resetn     (resetn),
        .issue_en   (issue_en),
        .issue_insn (issue_insn),
        .pcpi_valid (bus.pcpi_valid),
        .pcpi_insn  (bus.pcpi_insn)
    );

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench for matmul_job_sequencer: stream, threshold, gaps, timeout, abort, async reset.
module tb_matmul_job_sequencer;

    localparam logic [31:0] INSN_START = 32'h0000_700B;
    localparam logic [31:0] INSN_CLEAR = 32'h0000_500B;

    logic clk = 1'b0;
    logic resetn;
    logic job_start;
    logic job_load_thr;
    logic job_abort;
    logic job_busy;
    logic job_done;
    logic job_err;

    int checks = 0;
    int errors = 0;

    matmul_job_sequencer_if bus ();

    matmul_job_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .job_start    (job_start),
        .job_load_thr (job_load_thr),
        .job_abort    (job_abort),
        .job_busy     (job_busy),
        .job_done     (job_done),
        .job_err      (job_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_write(input int idx, input logic [15:0] v);
        logic [4:0] a;
        a = idx[4:0];
        return {1'b0, v, 3'b000, a, 7'b0001011};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    // Full job with s_valid held high; words are checked one cycle after acceptance.
    task automatic run_stream_job(input bit use_thr, input string tag);
        logic [15:0] w [28];
        int n;
        n = use_thr ? 28 : 27;
        for (int i = 0; i < 28; i++) w[i] = use_thr ? 16'(i * 5 - 50) : 16'(i + 1);
        if (use_thr) w[27] = 16'hFFBA;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h1234;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++; $display("FAIL %s idle_s_ready: got %b expected 0", tag, bus.s_ready);
        end
        job_start = 1'b1; job_load_thr = use_thr;
        tick;
        job_start = 1'b0; job_load_thr = 1'b0;
        #1;
        checks++;
        if ({job_busy, bus.s_ready} !== 2'b11) begin
            errors++; $display("FAIL %s load_entry busy/ready: got %b%b expected 11", tag,
                               job_busy, bus.s_ready);
        end
        for (int i = 0; i < n; i++) begin
            bus.s_data = w[i];
            tick;
            checks++;
            if ({bus.pcpi_valid, bus.pcpi_insn} !== {1'b1, exp_write(i, w[i])}) begin
                errors++; $display("FAIL %s write[%0d]: got v=%b insn=%h expected v=1 insn=%h",
                                   tag, i, bus.pcpi_valid, bus.pcpi_insn, exp_write(i, w[i]));
            end
        end
        if (use_thr) begin
            checks++;
            if (bus.pcpi_insn !== 32'h7FDD_0D8B) begin
                errors++; $display("FAIL %s thr_insn: got %h expected 7fdd0d8b", tag,
                                   bus.pcpi_insn);
            end
        end
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++; $display("FAIL %s start_s_ready: got %b expected 0", tag, bus.s_ready);
        end
        tick;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn} !== {1'b1, INSN_START}) begin
            errors++; $display("FAIL %s start_insn: got v=%b insn=%h expected v=1 insn=%h", tag,
                               bus.pcpi_valid, bus.pcpi_insn, INSN_START);
        end
        tick;
        checks++;
        if (bus.pcpi_valid !== 1'b0) begin
            errors++; $display("FAIL %s settle_idle: got %b expected 0", tag, bus.pcpi_valid);
        end
        bus.pcpi_ready = 1'b1;
        tick;
        bus.pcpi_ready = 1'b0;
        checks++;
        if (bus.pcpi_valid !== 1'b0) begin
            errors++; $display("FAIL %s pre_clear_idle: got %b expected 0", tag, bus.pcpi_valid);
        end
        tick;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn, job_done, job_err, job_busy} !==
            {1'b1, INSN_CLEAR, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL %s clear_done: got v=%b insn=%h done=%b err=%b busy=%b %s",
                               tag, bus.pcpi_valid, bus.pcpi_insn, job_done, job_err, job_busy,
                               "expected v=1 insn=0000500b done=1 err=0 busy=0");
        end
        bus.s_valid = 1'b0;
        tick;
        checks++;
        if ({job_done, bus.pcpi_valid} !== 2'b00) begin
            errors++; $display("FAIL %s done_pulse_end: got done=%b v=%b expected 0 0", tag,
                               job_done, bus.pcpi_valid);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        job_start = 1'b0; job_load_thr = 1'b0; job_abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.pcpi_wait = 1'b0; bus.pcpi_ready = 1'b0;
        tick;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn, bus.s_ready, job_busy, job_done, job_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got v=%b insn=%h rdy=%b busy=%b done=%b err=%b %s",
                               bus.pcpi_valid, bus.pcpi_insn, bus.s_ready, job_busy, job_done,
                               job_err, "expected all 0");
        end
        resetn = 1'b1;
        tick;
        checks++;
        if ({job_busy, bus.pcpi_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_release_idle: got busy=%b v=%b expected 0 0", job_busy,
                               bus.pcpi_valid);
        end
    endtask

    task automatic test_back_to_back;
        run_stream_job(1'b0, "b2b");
    endtask

    task automatic test_threshold;
        run_stream_job(1'b1, "thr");
    endtask

    // Alternating valid; a stray job_start mid-load must not restart the word count.
    task automatic test_gapped;
        logic [15:0] d;
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            d = 16'hA000 + 16'(i);
            bus.s_valid = 1'b1; bus.s_data = d;
            tick;
            checks++;
            if ({bus.pcpi_valid, bus.pcpi_insn} !== {1'b1, exp_write(i, d)}) begin
                errors++; $display("FAIL gap write[%0d]: got v=%b insn=%h expected v=1 insn=%h", i,
                                   bus.pcpi_valid, bus.pcpi_insn, exp_write(i, d));
            end
            if (i < 26) begin
                bus.s_valid = 1'b0; bus.s_data = 16'hDEAD;
                if (i == 10) begin job_start = 1'b1; job_load_thr = 1'b1; end
                tick;
                job_start = 1'b0; job_load_thr = 1'b0;
                #1;
                checks++;
                if ({bus.pcpi_valid, bus.s_ready} !== 2'b01) begin
                    errors++; $display("FAIL gap idle[%0d]: got v=%b rdy=%b expected v=0 rdy=1", i,
                                       bus.pcpi_valid, bus.s_ready);
                end
            end
        end
        bus.s_valid = 1'b0;
        tick;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn} !== {1'b1, INSN_START}) begin
            errors++; $display("FAIL gap start_insn: got v=%b insn=%h expected v=1 insn=%h",
                               bus.pcpi_valid, bus.pcpi_insn, INSN_START);
        end
        tick;
        bus.pcpi_ready = 1'b1; bus.pcpi_wait = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if ({bus.pcpi_valid, job_done} !== 2'b00) begin
                errors++; $display("FAIL gap wait_hold[%0d]: got v=%b done=%b expected 0 0", k,
                                   bus.pcpi_valid, job_done);
            end
        end
        bus.pcpi_wait = 1'b0;
        tick;
        bus.pcpi_ready = 1'b0;
        tick;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn, job_done, job_err} !==
            {1'b1, INSN_CLEAR, 1'b1, 1'b0}) begin
            errors++; $display("FAIL gap clear_done: got v=%b insn=%h done=%b err=%b %s",
                               bus.pcpi_valid, bus.pcpi_insn, job_done, job_err,
                               "expected v=1 insn=0000500b done=1 err=0");
        end
        tick;
    endtask

    task automatic test_timeout;
        int  cnt;
        bit  found;
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.s_data = 16'(i);
            tick;
        end
        bus.s_valid = 1'b0;
        tick;
        tick;
        checks++;
        if (job_busy !== 1'b1) begin
            errors++; $display("FAIL tmo wait_busy: got %b expected 1", job_busy);
        end
        cnt = 0; found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick;
            cnt++;
            if (bus.pcpi_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || cnt != 65) begin
            errors++; $display("FAIL tmo clear_delay: got %0d cycles (found=%b) expected 65", cnt,
                               found);
        end
        checks++;
        if ({bus.pcpi_insn, job_done, job_err} !== {INSN_CLEAR, 1'b1, 1'b1}) begin
            errors++; $display("FAIL tmo clear_done: got insn=%h done=%b err=%b %s", bus.pcpi_insn,
                               job_done, job_err, "expected insn=0000500b done=1 err=1");
        end
        tick;
        checks++;
        if ({job_err, job_done, job_busy} !== 3'b100) begin
            errors++; $display("FAIL tmo err_held: got err=%b done=%b busy=%b expected 1 0 0",
                               job_err, job_done, job_busy);
        end
    endtask

    task automatic test_abort;
        job_start = 1'b1; job_abort = 1'b1;
        tick;
        job_start = 1'b0; job_abort = 1'b0;
        #1;
        checks++;
        if ({job_busy, job_err, bus.s_ready} !== 3'b101) begin
            errors++; $display("FAIL abort start_wins: got busy=%b err=%b rdy=%b expected 1 0 1",
                               job_busy, job_err, bus.s_ready);
        end
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.s_data = 16'(50 + i);
            tick;
            checks++;
            if ({bus.pcpi_valid, bus.pcpi_insn} !== {1'b1, exp_write(i, 16'(50 + i))}) begin
                errors++; $display("FAIL abort write[%0d]: got v=%b insn=%h expected v=1 insn=%h",
                                   i, bus.pcpi_valid, bus.pcpi_insn, exp_write(i, 16'(50 + i)));
            end
        end
        bus.s_data = 16'd55; job_abort = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++; $display("FAIL abort s_ready: got %b expected 0", bus.s_ready);
        end
        tick;
        job_abort = 1'b0;
        checks++;
        if ({bus.pcpi_valid, job_busy} !== 2'b01) begin
            errors++; $display("FAIL abort no_write: got v=%b busy=%b expected v=0 busy=1",
                               bus.pcpi_valid, job_busy);
        end
        tick;
        bus.s_valid = 1'b0;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn, job_done, job_err, job_busy} !==
            {1'b1, INSN_CLEAR, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL abort clear_done: got v=%b insn=%h done=%b err=%b busy=%b %s",
                               bus.pcpi_valid, bus.pcpi_insn, job_done, job_err, job_busy,
                               "expected v=1 insn=0000500b done=1 err=1 busy=0");
        end
        tick;
        checks++;
        if ({bus.pcpi_valid, job_done, job_err} !== 3'b001) begin
            errors++; $display("FAIL abort after: got v=%b done=%b err=%b expected 0 0 1",
                               bus.pcpi_valid, job_done, job_err);
        end
    endtask

    task automatic test_async_reset;
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.s_data = 16'(i * 3);
            tick;
        end
        for (int k = 0; k < 4; k++) tick;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.pcpi_valid, bus.pcpi_insn, bus.s_ready, job_busy, job_done, job_err} !== '0) begin
            errors++; $display("FAIL areset outputs: got v=%b insn=%h rdy=%b busy=%b done=%b err=%b %s",
                               bus.pcpi_valid, bus.pcpi_insn, bus.s_ready, job_busy, job_done,
                               job_err, "expected all 0");
        end
        tick;
        tick;
        resetn = 1'b1;
        bus.s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({bus.pcpi_valid, job_busy} !== 2'b00) begin
                errors++; $display("FAIL areset no_clear[%0d]: got v=%b busy=%b expected 0 0", k,
                                   bus.pcpi_valid, job_busy);
            end
        end
        run_stream_job(1'b0, "post_reset");
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_threshold;
        test_gapped;
        test_timeout;
        test_abort;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
